// File: rtl/branch_comp.sv
// branch_comp: RV32I branch comparator producing BrEq/BrLt for BEQ/BNE/BLT/BGE/BLTU/BGEU.
// Define BRANCH_COMP_REG_OUT_EN to register the flags (1-cycle latency, async active-low clear).
module branch_comp #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] DataA,
  input  logic [DWIDTH-1:0] DataB,
  input  logic              BrUn,
  output logic              BrEq,
  output logic              BrLt
);
  // Extend by one bit: sign-extend in signed mode, zero-extend in unsigned mode,
  // then a single signed DWIDTH+1 compare covers both without overflow.
  logic [DWIDTH:0] w_a;
  logic [DWIDTH:0] w_b;
  logic            w_eq;
  logic            w_lt;
  assign w_a  = {~BrUn & DataA[DWIDTH-1], DataA};
  assign w_b  = {~BrUn & DataB[DWIDTH-1], DataB};
  assign w_eq = DataA == DataB;
  assign w_lt = $signed(w_a) < $signed(w_b);
`ifdef BRANCH_COMP_REG_OUT_EN
  logic r_eq;
  logic r_lt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eq <= 1'b0;
      r_lt <= 1'b0;
    end else begin
      r_eq <= w_eq;
      r_lt <= w_lt;
    end
  end
  assign BrEq = r_eq;
  assign BrLt = r_lt;
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n};
  assign BrEq = w_eq;
  assign BrLt = w_lt;
`endif
endmodule

// File: tb/tb_branch_comp.sv
// tb_branch_comp: directed-vector bench for branch_comp; also covers the registered
// build when BRANCH_COMP_REG_OUT_EN is defined.
module tb_branch_comp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        BrUn = 1'b0;
  logic [31:0] DataA = '0;
  logic [31:0] DataB = '0;
  logic        BrEq;
  logic        BrLt;
  int          n_chk = 0;
  int          n_pass = 0;

  typedef struct packed {
    logic        un;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  exp;
  } vec_t;

  vec_t v [22];

  always #5 clk = ~clk;

  branch_comp #(.DWIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .DataA(DataA),
    .DataB(DataB),
    .BrUn (BrUn),
    .BrEq (BrEq),
    .BrLt (BrLt)
  );

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: {BrEq,BrLt} got %b expected %b", tag, got, exp);
  endtask

  task automatic apply(input vec_t x);
`ifdef BRANCH_COMP_REG_OUT_EN
    @(negedge clk);
`endif
    BrUn  = x.un;
    DataA = x.a;
    DataB = x.b;
`ifdef BRANCH_COMP_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
  endtask

  initial begin
    // {un, a, b, {eq,lt}}
    v = '{
      '{1'b1, 32'hFFFFFFEC, 32'hFFFFFFF6, 2'b01},
      '{1'b1, 32'hFFFFFFEC, 32'h0000000A, 2'b00},
      '{1'b1, 32'h00000014, 32'hFFFFFFF6, 2'b01},
      '{1'b1, 32'h00000014, 32'h0000000A, 2'b00},
      '{1'b0, 32'hFFFFFFEC, 32'hFFFFFFF6, 2'b01},
      '{1'b0, 32'hFFFFFFEC, 32'h0000000A, 2'b01},
      '{1'b0, 32'h00000014, 32'hFFFFFFF6, 2'b00},
      '{1'b0, 32'h00000014, 32'h0000000A, 2'b00},
      '{1'b0, 32'h12345678, 32'h12345678, 2'b10},
      '{1'b1, 32'h12345678, 32'h12345678, 2'b10},
      '{1'b0, 32'h80000000, 32'h7FFFFFFF, 2'b01},
      '{1'b1, 32'h80000000, 32'h7FFFFFFF, 2'b00},
      '{1'b0, 32'hFFFFFFFF, 32'h00000000, 2'b01},
      '{1'b1, 32'hFFFFFFFF, 32'h00000000, 2'b00},
      '{1'b0, 32'h00000000, 32'h00000000, 2'b10},
      '{1'b1, 32'h00000000, 32'h00000000, 2'b10},
      '{1'b0, 32'h7FFFFFFF, 32'h80000000, 2'b00},
      '{1'b1, 32'h7FFFFFFF, 32'h80000000, 2'b01},
      '{1'b0, 32'h00000000, 32'hFFFFFFFF, 2'b00},
      '{1'b1, 32'h00000000, 32'hFFFFFFFF, 2'b01},
      '{1'b0, 32'h80000000, 32'h80000001, 2'b01},
      '{1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 2'b01}
    };
`ifdef BRANCH_COMP_REG_OUT_EN
    DataA = 32'd5;
    DataB = 32'd5;
    #1;
    check("rst_clear", {BrEq, BrLt}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pre_edge", {BrEq, BrLt}, 2'b00);
    @(posedge clk);
    #1;
    check("first_edge", {BrEq, BrLt}, 2'b10);
    @(negedge clk);
    DataA = 32'd3;
    #2;
    check("hold_between_edges", {BrEq, BrLt}, 2'b10);
`else
    // rst_n held low: combinational result must be unaffected
    apply(v[0]);
    check("rst_no_effect", {BrEq, BrLt}, v[0].exp);
    rst_n = 1'b1;
`endif
    for (int i = 0; i < 22; i++) begin
      apply(v[i]);
      check($sformatf("vec%0d", i), {BrEq, BrLt}, v[i].exp);
    end
`ifdef BRANCH_COMP_REG_OUT_EN
    apply(v[8]);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", {BrEq, BrLt}, 2'b00);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
